// File: rtl/spi_shift_engine.sv
// Byte-level SPI master shifter: CS/SCK/MOSI generation with MISO capture.
// Parameterized SCK divider and SPI mode; back-to-back bytes keep CS low.
module spi_shift_engine #(
    parameter int unsigned CLK_DIV = 4,
    parameter bit          CPOL    = 1'b0,
    parameter bit          CPHA    = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic [7:0] data_i,
    output logic [7:0] data_o,
    output logic       data_ready,
    output logic       cs,
    output logic       sck,
    output logic       mosi,
    input  logic       miso
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        DONE,
        GAP
    } state_e;

    localparam logic [7:0] DIV_M1 = 8'(CLK_DIV - 1);

    state_e     state_q;
    logic [7:0] cnt_q;
    logic [4:0] edge_q;
    logic [7:0] tx_q;
    logic [7:0] rx_q;
    logic [7:0] data_q;
    logic       ready_q;
    logic       cs_q;
    logic       sck_q;
    logic       mosi_q;

    logic [4:0] k_d;
    logic       samp_d;
    logic       drive_d;

    // k_d is the number of the toggle about to happen (odd = leading edge)
    always_comb begin
        k_d     = edge_q + 5'd1;
        samp_d  = CPHA ? ~k_d[0] : k_d[0];
        drive_d = CPHA ? (k_d[0] && (k_d >= 5'd3))
                       : (~k_d[0] && (k_d <= 5'd14));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 8'd0;
            edge_q  <= 5'd0;
            tx_q    <= 8'd0;
            rx_q    <= 8'd0;
            data_q  <= 8'd0;
            ready_q <= 1'b0;
            cs_q    <= 1'b1;
            sck_q   <= CPOL;
            mosi_q  <= 1'b1;
        end else begin
            ready_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (en) begin
                        tx_q    <= data_i;
                        mosi_q  <= data_i[7];
                        cs_q    <= 1'b0;
                        cnt_q   <= DIV_M1;
                        edge_q  <= 5'd0;
                        state_q <= LEAD;
                    end
                end
                LEAD, SHIFT: begin
                    if (cnt_q != 8'd0) begin
                        cnt_q <= cnt_q - 8'd1;
                    end else if (edge_q == 5'd16) begin
                        data_q  <= rx_q;
                        ready_q <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q   <= DIV_M1;
                        edge_q  <= k_d;
                        sck_q   <= ~sck_q;
                        state_q <= SHIFT;
                        if (samp_d) begin
                            rx_q <= {rx_q[6:0], miso};
                        end
                        if (drive_d) begin
                            tx_q   <= {tx_q[6:0], 1'b0};
                            mosi_q <= tx_q[6];
                        end
                    end
                end
                DONE: begin
                    state_q <= GAP;
                end
                GAP: begin
                    if (en) begin
                        tx_q    <= data_i;
                        mosi_q  <= data_i[7];
                        cnt_q   <= DIV_M1;
                        edge_q  <= 5'd0;
                        state_q <= LEAD;
                    end else begin
                        cs_q    <= 1'b1;
                        mosi_q  <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign data_o     = data_q;
    assign data_ready = ready_q;
    assign cs         = cs_q;
    assign sck        = sck_q;
    assign mosi       = mosi_q;

endmodule

// File: tb/tb_spi_shift_engine.sv
// Directed bench for spi_shift_engine: three instances cover mode 0 at
// divider 2 and 4 (loopback and slave model) and mode 3 at divider 3.
module tb_spi_shift_engine;

    logic       clk;
    logic       rst_n;
    logic [2:0] en;
    logic [7:0] din [3];
    logic [7:0] dout0, dout1, dout2;
    logic [2:0] rdy;
    logic [2:0] cs;
    logic [2:0] sck;
    logic [2:0] mosi;
    logic       miso0, miso1, miso2;

    int tests;
    int fails;

    int rise0, rise1, rise2;
    int rc0, rc1, rc2;
    int csr1;
    logic [7:0] mcap0, mcap1, mcap2;
    logic [7:0] slv_byte;
    logic [2:0] bidx;

    spi_shift_engine #(.CLK_DIV(2), .CPOL(1'b0), .CPHA(1'b0)) u0 (
        .clk(clk), .rst_n(rst_n), .en(en[0]), .data_i(din[0]),
        .data_o(dout0), .data_ready(rdy[0]), .cs(cs[0]), .sck(sck[0]),
        .mosi(mosi[0]), .miso(miso0)
    );

    spi_shift_engine #(.CLK_DIV(4), .CPOL(1'b0), .CPHA(1'b0)) u1 (
        .clk(clk), .rst_n(rst_n), .en(en[1]), .data_i(din[1]),
        .data_o(dout1), .data_ready(rdy[1]), .cs(cs[1]), .sck(sck[1]),
        .mosi(mosi[1]), .miso(miso1)
    );

    spi_shift_engine #(.CLK_DIV(3), .CPOL(1'b1), .CPHA(1'b1)) u2 (
        .clk(clk), .rst_n(rst_n), .en(en[2]), .data_i(din[2]),
        .data_o(dout2), .data_ready(rdy[2]), .cs(cs[2]), .sck(sck[2]),
        .mosi(mosi[2]), .miso(miso2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // u0/u2 loop back; u1 sees a slave that advances one bit per sample edge
    assign miso0 = mosi[0];
    assign miso2 = mosi[2];
    assign bidx  = 3'(rise1);
    assign miso1 = slv_byte[3'd7 - bidx];

    always @(posedge sck[0]) if (cs[0] === 1'b0) begin
        rise0++;
        mcap0 = {mcap0[6:0], mosi[0]};
    end
    always @(posedge sck[1]) if (cs[1] === 1'b0) begin
        rise1++;
        mcap1 = {mcap1[6:0], mosi[1]};
    end
    always @(posedge sck[2]) if (cs[2] === 1'b0) begin
        rise2++;
        mcap2 = {mcap2[6:0], mosi[2]};
    end
    always @(posedge rdy[0]) rc0++;
    always @(posedge rdy[1]) rc1++;
    always @(posedge rdy[2]) rc2++;
    always @(posedge cs[1]) csr1++;

    task automatic wait_rdy(input int u, input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            if (rdy[u] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    task automatic wait_cs_hi(input int u, input int lim, output int n);
        n = -1;
        for (int i = 1; i <= lim; i++) begin
            @(posedge clk);
            #1;
            if (cs[u] === 1'b1) begin
                n = i;
                break;
            end
        end
    endtask

    // Returns #1 after the accepting edge E0
    task automatic start(input int u, input logic [7:0] b);
        @(negedge clk);
        en[u]  = 1'b1;
        din[u] = b;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        logic [7:0] douts [3];
        douts[0] = dout0;
        douts[1] = dout1;
        douts[2] = dout2;
        for (int u = 0; u < 3; u++) begin
            tests++;
            if (cs[u] !== 1'b1) begin
                fails++;
                $display("FAIL rst_cs u%0d got %b want 1", u, cs[u]);
            end
            tests++;
            if (sck[u] !== (u == 2)) begin
                fails++;
                $display("FAIL rst_sck u%0d got %b want %0d", u, sck[u], u == 2);
            end
            tests++;
            if (mosi[u] !== 1'b1) begin
                fails++;
                $display("FAIL rst_mosi u%0d got %b want 1", u, mosi[u]);
            end
            tests++;
            if (rdy[u] !== 1'b0) begin
                fails++;
                $display("FAIL rst_rdy u%0d got %b want 0", u, rdy[u]);
            end
            tests++;
            if (douts[u] !== 8'h00) begin
                fails++;
                $display("FAIL rst_dout u%0d got %h want 00", u, douts[u]);
            end
        end
    endtask

    task automatic test_basic;
        int n, m, r;
        r = rise0;
        start(0, 8'hA5);
        tests++;
        if (cs[0] !== 1'b0) begin
            fails++;
            $display("FAIL basic_cs_fall got %b want 0", cs[0]);
        end
        @(negedge clk);
        en[0] = 1'b0;
        wait_rdy(0, 100, n);
        tests++;
        if (n != 34) begin
            fails++;
            $display("FAIL basic_rdy_lat got %0d want 34", n);
        end
        tests++;
        if (dout0 !== 8'hA5) begin
            fails++;
            $display("FAIL basic_dout got %h want a5", dout0);
        end
        tests++;
        if (rise0 - r != 8) begin
            fails++;
            $display("FAIL basic_rises got %0d want 8", rise0 - r);
        end
        wait_cs_hi(0, 10, m);
        tests++;
        if (m != 2) begin
            fails++;
            $display("FAIL basic_cs_rise got %0d want 2", m);
        end
    endtask

    task automatic test_div4_slave;
        int n, m, r;
        slv_byte = 8'h3C;
        r = rise1;
        start(1, 8'hFF);
        @(negedge clk);
        en[1] = 1'b0;
        wait_rdy(1, 200, n);
        tests++;
        if (n != 68) begin
            fails++;
            $display("FAIL div4_rdy_lat got %0d want 68", n);
        end
        tests++;
        if (mcap1 !== 8'hFF) begin
            fails++;
            $display("FAIL div4_mosi got %h want ff", mcap1);
        end
        tests++;
        if (dout1 !== 8'h3C) begin
            fails++;
            $display("FAIL div4_dout got %h want 3c", dout1);
        end
        tests++;
        if (rise1 - r != 8) begin
            fails++;
            $display("FAIL div4_rises got %0d want 8", rise1 - r);
        end
        wait_cs_hi(1, 10, m);
        tests++;
        if (m != 2) begin
            fails++;
            $display("FAIL div4_cs_rise got %0d want 2", m);
        end
    endtask

    task automatic test_back_to_back;
        int n, n2, m, rc, cr;
        slv_byte = 8'h3C;
        rc = rc1;
        cr = csr1;
        start(1, 8'h01);
        wait_rdy(1, 200, n);
        tests++;
        if (mcap1 !== 8'h01 || dout1 !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_byte1 got mosi %h dout %h want 01 3c", mcap1, dout1);
        end
        @(posedge clk);
        #1;
        din[1] = 8'h80;
        wait_rdy(1, 200, n2);
        en[1] = 1'b0;
        tests++;
        if (n2 + 1 != 70) begin
            fails++;
            $display("FAIL b2b_period got %0d want 70", n2 + 1);
        end
        tests++;
        if (mcap1 !== 8'h80 || dout1 !== 8'h3C) begin
            fails++;
            $display("FAIL b2b_byte2 got mosi %h dout %h want 80 3c", mcap1, dout1);
        end
        wait_cs_hi(1, 10, m);
        repeat (5) @(posedge clk);
        #1;
        tests++;
        if (csr1 - cr != 1 || m != 2) begin
            fails++;
            $display("FAIL b2b_cs got rises %0d lat %0d want 1 2", csr1 - cr, m);
        end
        tests++;
        if (rc1 - rc != 2) begin
            fails++;
            $display("FAIL b2b_pulses got %0d want 2", rc1 - rc);
        end
    endtask

    task automatic test_mode3;
        int n, m, r;
        tests++;
        if (sck[2] !== 1'b1) begin
            fails++;
            $display("FAIL m3_idle_sck got %b want 1", sck[2]);
        end
        r = rise2;
        start(2, 8'h5A);
        @(negedge clk);
        en[2] = 1'b0;
        wait_rdy(2, 200, n);
        tests++;
        if (n != 51) begin
            fails++;
            $display("FAIL m3_rdy_lat got %0d want 51", n);
        end
        tests++;
        if (dout2 !== 8'h5A) begin
            fails++;
            $display("FAIL m3_dout got %h want 5a", dout2);
        end
        tests++;
        if (mcap2 !== 8'h5A || rise2 - r != 8) begin
            fails++;
            $display("FAIL m3_mosi got %h rises %0d want 5a 8", mcap2, rise2 - r);
        end
        wait_cs_hi(2, 10, m);
        tests++;
        if (m != 2 || sck[2] !== 1'b1) begin
            fails++;
            $display("FAIL m3_end got cs lat %0d sck %b want 2 1", m, sck[2]);
        end
    endtask

    task automatic test_en_drop;
        int n, m, rc;
        rc = rc0;
        start(0, 8'h3C);
        repeat (7) @(posedge clk);
        @(negedge clk);
        en[0] = 1'b0;
        wait_rdy(0, 100, n);
        tests++;
        if (n != 27) begin
            fails++;
            $display("FAIL drop_rdy_lat got %0d want 27", n);
        end
        tests++;
        if (dout0 !== 8'h3C) begin
            fails++;
            $display("FAIL drop_dout got %h want 3c", dout0);
        end
        wait_cs_hi(0, 10, m);
        repeat (3) @(posedge clk);
        #1;
        tests++;
        if (m != 2 || rc0 - rc != 1) begin
            fails++;
            $display("FAIL drop_end got cs lat %0d pulses %0d want 2 1", m, rc0 - rc);
        end
    endtask

    task automatic test_reset_mid;
        int n, rc;
        rc = rc0;
        start(0, 8'h96);
        @(negedge clk);
        en[0] = 1'b0;
        repeat (15) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        tests++;
        if (cs[0] !== 1'b1 || sck[0] !== 1'b0 || mosi[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_pins got cs %b sck %b mosi %b want 1 0 1",
                     cs[0], sck[0], mosi[0]);
        end
        tests++;
        if (dout0 !== 8'h00) begin
            fails++;
            $display("FAIL mid_rst_dout got %h want 00", dout0);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        repeat (40) @(posedge clk);
        #1;
        tests++;
        if (rc0 != rc || cs[0] !== 1'b1) begin
            fails++;
            $display("FAIL mid_rst_quiet got pulses %0d cs %b want 0 1", rc0 - rc, cs[0]);
        end
        start(0, 8'hC7);
        @(negedge clk);
        en[0] = 1'b0;
        wait_rdy(0, 100, n);
        tests++;
        if (n != 34 || dout0 !== 8'hC7) begin
            fails++;
            $display("FAIL mid_rst_after got lat %0d dout %h want 34 c7", n, dout0);
        end
    endtask

    initial begin
        tests    = 0;
        fails    = 0;
        rst_n    = 1'b0;
        en       = 3'b000;
        din[0]   = 8'h00;
        din[1]   = 8'h00;
        din[2]   = 8'h00;
        slv_byte = 8'h00;
        repeat (3) @(posedge clk);
        #1;
        test_reset;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        test_basic;
        test_div4_slave;
        test_back_to_back;
        test_mode3;
        test_en_drop;
        test_reset_mid;
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/spi_shift_engine.md
# spi_shift_engine

Byte-level SPI serializer that sits directly downstream of the SPI controller's MOSI FIFO sequencer. It accepts a byte on a level-sensitive enable, drives chip-select/SCK/MOSI with a parameterized clock divider and SPI mode, samples MISO, and returns the received byte with a one-cycle ready pulse. Back-to-back bytes keep chip-select asserted while enable stays high.

## Interface
- `CLK_DIV`, default 4: SCK half-period in `clk` cycles; legal range 2..255.
- `CPOL`, default 0: SCK idle level.
- `CPHA`, default 0: 0 = sample on leading edge, 1 = sample on trailing edge.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `en` in 1: level request; sampled only in IDLE and GAP.
- `data_i` in 8: byte to transmit; captured on the edge that leaves IDLE or GAP.
- `data_o` out 8: last received byte; valid from the `data_ready` cycle until the next DONE.
- `data_ready` out 1: one-cycle pulse; byte complete.
- `cs` out 1: chip select, active low.
- `sck` out 1: serial clock.
- `mosi` out 1: serial data out, MSB first.
- `miso` in 1: serial data in, MSB first; synchronous to `sck`, no internal synchronizer.

## Operation
- All outputs are registered. Reset values: `cs`=1, `sck`=CPOL, `mosi`=1, `data_o`=0x00, `data_ready`=0, state IDLE, counters 0.
- States:
  - IDLE: `cs`=1. If `en`=1, load the TX shift register from `data_i`, set `cs`=0 and `mosi`=`data_i[7]`, and go to LEAD.
  - LEAD: hold for CLK_DIV cycles with `sck`=CPOL, then go to SHIFT.
  - SHIFT: toggle `sck` every CLK_DIV cycles, 16 toggles numbered k=1..16. Odd k is the leading edge, even k the trailing edge. After toggle 16, `sck`=CPOL.
    - CPHA=0: sample `miso` into the RX register at k=1,3,…,15. Shift TX and drive the next bit on `mosi` at k=2,4,…,14.
    - CPHA=1: drive the next bit on `mosi` at k=3,5,…,15 (bit 7 is already presented from LEAD). Sample at k=2,4,…,16.
    - Exit: after CLK_DIV further cycles (trail hold), go to DONE.
  - DONE: one cycle. `data_ready`=1 and `data_o` = RX register. `cs` stays 0. Go to GAP.
  - GAP: one cycle, giving the upstream registered sequencer a cycle to update `en` and `data_i`. On the next edge:
    - `en`=1: reload TX from `data_i`, set `mosi`=`data_i[7]`, and go to LEAD with `cs` held 0.
    - `en`=0: set `cs`=1 and `mosi`=1, and go to IDLE.
- `en` falling during LEAD, SHIFT or DONE is ignored; the current byte always completes. A change in `data_i` during that time is also ignored.
- A reset during any state immediately returns all outputs to their reset values, including `cs`=1. The partial byte is discarded and no `data_ready` is issued.
- Divider counter width is 8 bits; it reloads to CLK_DIV-1 on every toggle, so there is no wrap-around hazard.

## Timing
- Let E0 be the edge at which `en`=1 is accepted in IDLE.
  - `cs` falls after E0.
  - Toggle k occurs at E0 + k·CLK_DIV.
  - `data_ready` is high for exactly the cycle after E0 + 17·CLK_DIV.
- Continuous stream: byte period = 17·CLK_DIV + 2 cycles. `cs` stays low across bytes.
- `cs` is high for at least 1 cycle between bursts. IDLE accepts a new `en` on the edge after entry.
- `sck` never glitches. `cs` changes only while `sck`=CPOL.

## Test plan
- CLK_DIV=2, mode 0, `mosi` looped to `miso`, `en` high for one byte with `data_i`=0xA5:
  - `cs` falls one cycle after `en`.
  - 8 rising `sck` edges.
  - `data_ready` pulse at E0+34.
  - `data_o`=0xA5.
  - `cs` returns to 1 at E0+36.
- CLK_DIV=4, mode 0, slave model returns 0x3C while `data_i`=0xFF: `mosi` is high for all 8 bits and `data_o`=0x3C.
- Back-to-back: `en` held high, `data_i` changed 0x01→0x80 in the cycle after `data_ready`:
  - Exactly 2 `data_ready` pulses, 70 cycles apart at CLK_DIV=4.
  - `cs` low throughout.
  - Second byte on `mosi` is 0x80.
- CPOL=1, CPHA=1, CLK_DIV=3, loopback of 0x5A:
  - `sck` idles high.
  - `miso` is sampled on the rising (trailing) edges.
  - `data_o`=0x5A.
- `en` dropped 5 cycles into SHIFT: the byte still completes, `data_ready` pulses once, and `cs` rises after GAP.
- `rst_n` asserted mid-SHIFT: `cs`=1, `sck`=CPOL, `mosi`=1 and `data_o`=0x00 within the same cycle, with no `data_ready`. After release, a new byte transfers correctly.
